// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM port arbiter.
//   - default geometry (4 ports, 23-bit word address, 32-bit data)
//   - FSM state encodings (IDLE, REQ, WAIT) as fixed-width constants
//   - grant index / address / data typedefs for the default geometry
//   - idx_width(): grant index width for a given port count
package sdram_arb_pkg;

  localparam int unsigned DEF_N_PORTS    = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 23;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  typedef logic [$clog2(DEF_N_PORTS)-1:0] grant_t;
  typedef logic [DEF_ADDR_WIDTH-1:0]      addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0]      data_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
//   req   in  [N]   request vector
//   ptr   in  [IW]  first index to examine (wraps modulo N)
//   grant out [IW]  first requesting index at or after ptr
//   any   out 1     at least one request present
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned   j;
      logic [IW-1:0] jj;
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any   = 1'b1;
        grant = jj;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between N_PORTS requesters
// (ROM download writer, CPU program ROM, tile ROM, sprite ROM fetchers).
// One transaction at a time: IDLE arbitrates and registers the winner's
// request, REQ holds it on the controller until sdram_ack, WAIT holds the
// single outstanding read until sdram_valid.
//   clk, reset           system clock, synchronous active-high reset
//   port_addr/data/we    per-port request fields, held stable with port_req
//   port_req             per-port request, held until port_ack
//   port_ack             1-cycle pulse to the granted port on sdram_ack
//   port_valid           1-cycle pulse to the granted port on read data
//   port_q               read data (sdram_q pass-through, shared)
//   sdram_addr/data/we   registered request towards the controller
//   sdram_req            held until sdram_ack
//   sdram_ack/valid/q    controller responses
// Optional feature: define SDRAM_ARB_DOWNLOAD_PRIO_EN to make port 0
// (ROM download) win every arbitration it takes part in; remaining ports
// round-robin among themselves. Undefined: pure round-robin over all ports.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned N_PORTS    = DEF_N_PORTS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]  port_addr,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]  port_data,
  input  logic [N_PORTS-1:0]                  port_we,
  input  logic [N_PORTS-1:0]                  port_req,
  output logic [N_PORTS-1:0]                  port_ack,
  output logic [N_PORTS-1:0]                  port_valid,
  output logic [DATA_WIDTH-1:0]               port_q,
  output logic [ADDR_WIDTH-1:0]               sdram_addr,
  output logic [DATA_WIDTH-1:0]               sdram_data,
  output logic                                sdram_we,
  output logic                                sdram_req,
  input  logic                                sdram_ack,
  input  logic                                sdram_valid,
  input  logic [DATA_WIDTH-1:0]               sdram_q
);

  localparam int unsigned IW = idx_width(N_PORTS);

  state_t              state;
  logic [IW-1:0]       grant;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       pick;
  logic                pick_any;
  logic [N_PORTS-1:0]  pick_req;
  logic [N_PORTS-1:0]  grant_onehot;

`ifdef SDRAM_ARB_DOWNLOAD_PRIO_EN
  logic [IW-1:0] rr_grant;
  logic          rr_any;

  // Port 0 is taken out of the rotation and overrides its result.
  assign pick_req = {port_req[N_PORTS-1:1], 1'b0};

  rr_picker #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_picker (
    .req   (pick_req),
    .ptr   (ptr),
    .grant (rr_grant),
    .any   (rr_any)
  );

  assign pick     = port_req[0] ? '0 : rr_grant;
  assign pick_any = port_req[0] | rr_any;
`else
  assign pick_req = port_req;

  rr_picker #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_picker (
    .req   (pick_req),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );
`endif

  always_comb begin
    grant_onehot        = '0;
    grant_onehot[grant] = 1'b1;
  end

  // Responses are steered combinationally from the grant register so the
  // owning port sees ack/valid in the same cycle as the controller.
  assign port_ack   = (state == ST_REQ  && sdram_ack)   ? grant_onehot : '0;
  assign port_valid = (state == ST_WAIT && sdram_valid) ? grant_onehot : '0;
  assign port_q     = sdram_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      ptr        <= '0;
      sdram_req  <= 1'b0;
      sdram_we   <= 1'b0;
      sdram_addr <= '0;
      sdram_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant      <= pick;
            sdram_addr <= port_addr[pick];
            sdram_data <= port_data[pick];
            sdram_we   <= port_we[pick];
            sdram_req  <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            // ptr holds the first index searched next time: last grant + 1.
            ptr       <= (grant == IW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
            state     <= sdram_we ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdram_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus for sdram_arbiter with a scoreboard.
// Stimulus pushes expected issue/ack/valid events; a monitor pops and
// compares whenever the DUT raises sdram_req, port_ack or port_valid.
module tb_sdram_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;

  localparam int K_ISSUE = 0;
  localparam int K_ACK   = 1;
  localparam int K_VALID = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NP-1:0][AW-1:0]   port_addr = '0;
  logic [NP-1:0][DW-1:0]   port_data = '0;
  logic [NP-1:0]           port_we = '0;
  logic [NP-1:0]           port_req = '0;
  logic [NP-1:0]           port_ack;
  logic [NP-1:0]           port_valid;
  logic [DW-1:0]           port_q;
  logic [AW-1:0]           sdram_addr;
  logic [DW-1:0]           sdram_data;
  logic                    sdram_we;
  logic                    sdram_req;
  logic                    sdram_ack = 1'b0;
  logic                    sdram_valid = 1'b0;
  logic [DW-1:0]           sdram_q = '0;

  sdram_arbiter #(
    .N_PORTS    (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .port_addr   (port_addr),
    .port_data   (port_data),
    .port_we     (port_we),
    .port_req    (port_req),
    .port_ack    (port_ack),
    .port_valid  (port_valid),
    .port_q      (port_q),
    .sdram_addr  (sdram_addr),
    .sdram_data  (sdram_data),
    .sdram_we    (sdram_we),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_valid (sdram_valid),
    .sdram_q     (sdram_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic req_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int port, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic we);
    exp_t e;
    e.kind = kind; e.port = port; e.addr = a; e.data = d; e.we = we;
    sb.push_back(e);
  endtask

  // One transaction: issue + ack, plus the read-data event when with_valid.
  task automatic push_txn(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic we, input bit with_valid);
    push(K_ISSUE, port, a, d, we);
    push(K_ACK, port, a, d, we);
    if (with_valid) push(K_VALID, port, a, d, we);
  endtask

  task automatic pop_expect(input int kind, input string name, output exp_t e, output bit ok);
    checks++;
    ok = 1'b0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event, got kind %0d, expected none", name, kind);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL %s: got event kind %0d, expected kind %0d (port %0d)", name, kind, e.kind, e.port);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    bit   ok;
    logic [NP-1:0] oh;
    req_d = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (sdram_req === 1'b1 && req_d !== 1'b1) begin
          pop_expect(K_ISSUE, "issue", e, ok);
          if (ok) begin
            check($sformatf("issue_addr p%0d", e.port), 64'(sdram_addr), 64'(e.addr));
            check($sformatf("issue_we p%0d", e.port), 64'(sdram_we), 64'(e.we));
            if (e.we) check($sformatf("issue_data p%0d", e.port), 64'(sdram_data), 64'(e.data));
          end
        end
        if (port_ack !== '0) begin
          pop_expect(K_ACK, "ack", e, ok);
          if (ok) begin
            oh = NP'(1) << e.port;
            check($sformatf("ack_port p%0d", e.port), 64'(port_ack), 64'(oh));
          end
        end
        if (port_valid !== '0) begin
          pop_expect(K_VALID, "valid", e, ok);
          if (ok) begin
            oh = NP'(1) << e.port;
            check($sformatf("valid_port p%0d", e.port), 64'(port_valid), 64'(oh));
            check($sformatf("valid_q p%0d", e.port), 64'(port_q), 64'(e.data));
          end
        end
      end
      req_d = sdram_req;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller model: wait for sdram_req, ack after ack_dly cycles, return
  // read data valid_dly cycles after the ack (valid_dly 0 = never).
  task automatic serve(input int port, input int ack_dly, input int valid_dly,
                       input logic [DW-1:0] q, input bit hold, input bit valid_with_ack);
    int n;
    bit rd;
    n = 0;
    while (sdram_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (sdram_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout p%0d: sdram_req got 0, expected 1", port);
      return;
    end
    repeat (ack_dly) tick();
    rd = (sdram_we == 1'b0);
    sdram_ack = 1'b1;
    sdram_q   = q;
    if (valid_with_ack) sdram_valid = 1'b1;
    tick();
    sdram_ack   = 1'b0;
    sdram_valid = 1'b0;
    if (!hold) port_req[port] = 1'b0;
    if (rd && valid_dly > 0) begin
      repeat (valid_dly - 1) tick();
      sdram_valid = 1'b1;
      tick();
      sdram_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    port_req = '0;
    sdram_ack = 1'b0;
    sdram_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin : stimulus
    int          order[5];
    logic [DW-1:0] qv;

    // Reset state
    do_reset();
    check("rst_sdram_req", 64'(sdram_req), 64'(0));
    check("rst_sdram_we", 64'(sdram_we), 64'(0));
    check("rst_sdram_addr", 64'(sdram_addr), 64'(0));
    check("rst_sdram_data", 64'(sdram_data), 64'(0));
    check("rst_port_ack", 64'(port_ack), 64'(0));
    check("rst_port_valid", 64'(port_valid), 64'(0));

    // 1: single read on port 2, ack after 3, valid after 5
    port_addr[2] = 23'h000100;
    port_we[2]   = 1'b0;
    push_txn(2, 23'h000100, 32'hDEADBEEF, 1'b0, 1'b1);
    port_req[2] = 1'b1;
    check("t1_req_before", 64'(sdram_req), 64'(0));
    tick();
    check("t1_req_latency1", 64'(sdram_req), 64'(1));
    serve(2, 3, 5, 32'hDEADBEEF, 1'b0, 1'b0);
    repeat (2) tick();

    // 2: all ports read continuously from reset -> 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NP; i++) begin
      port_addr[i] = AW'(32'h200 + i);
      port_we[i]   = 1'b0;
    end
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      qv = 32'hA0000000 + 32'(k);
      push_txn(order[k], AW'(32'h200 + order[k]), qv, 1'b0, 1'b1);
    end
    port_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      qv = 32'hA0000000 + 32'(k);
      serve(order[k], 1, 2, qv, 1'b1, 1'b0);
    end
    port_req = '0;
    repeat (2) tick();

    // 3: port 1 write to top address, port 2 read waiting behind it
    port_addr[1] = 23'h7FFFFF;
    port_data[1] = 32'h12345678;
    port_we[1]   = 1'b1;
    port_addr[2] = 23'h000300;
    port_we[2]   = 1'b0;
    push_txn(1, 23'h7FFFFF, 32'h12345678, 1'b1, 1'b0);
    push_txn(2, 23'h000300, 32'h0, 1'b0, 1'b0);
    port_req = 4'b0110;
    serve(1, 1, 0, 32'h0, 1'b0, 1'b0);
    check("t3_gap_after_ack", 64'(sdram_req), 64'(0));
    tick();
    check("t3_next_issue", 64'(sdram_req), 64'(1));
    check("t3_next_is_read", 64'(sdram_we), 64'(0));
    // Leave the port 2 read in WAIT (no data returned)
    serve(2, 1, 0, 32'h0, 1'b0, 1'b0);

    // 4: reset in WAIT, stale sdram_valid 2 cycles later; next grant port 0
    reset = 1'b1;
    port_addr[0] = 23'h000400;
    port_we[0]   = 1'b0;
    port_addr[3] = 23'h000403;
    port_we[3]   = 1'b0;
    push_txn(0, 23'h000400, 32'h11110000, 1'b0, 1'b1);
    push_txn(3, 23'h000403, 32'h33330000, 1'b0, 1'b1);
    port_req = 4'b1001;
    tick();
    reset = 1'b0;
    check("t4_req_after_reset", 64'(sdram_req), 64'(0));
    check("t4_valid_after_reset", 64'(port_valid), 64'(0));
    tick();
    sdram_valid = 1'b1;
    sdram_q     = 32'hFFFF0000;
    tick();
    sdram_valid = 1'b0;
    serve(0, 1, 2, 32'h11110000, 1'b0, 1'b0);
    // sdram_valid together with sdram_ack in REQ must be ignored
    serve(3, 2, 3, 32'h33330000, 1'b0, 1'b1);
    repeat (2) tick();

    // 5: port 0 streams writes while port 3 reads
    port_addr[0] = 23'h000500;
    port_data[0] = 32'hCAFE0001;
    port_we[0]   = 1'b1;
    port_addr[3] = 23'h000503;
    port_we[3]   = 1'b0;
`ifdef SDRAM_ARB_DOWNLOAD_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 3, 0, 3, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      if (order[k] == 0) push_txn(0, 23'h000500, 32'hCAFE0001, 1'b1, 1'b0);
      else push_txn(3, 23'h000503, 32'h50000000 + 32'(k), 1'b0, 1'b1);
    end
    port_req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      serve(order[k], 1, 2, 32'h50000000 + 32'(k), 1'b1, 1'b0);
    end
    port_req = '0;
    repeat (3) tick();

    // 6: sdram_valid in IDLE with no request is ignored, state stays IDLE
    sdram_valid = 1'b1;
    sdram_q     = 32'h66666666;
    tick();
    sdram_valid = 1'b0;
    check("t6_no_req", 64'(sdram_req), 64'(0));
    check("t6_no_valid", 64'(port_valid), 64'(0));
    tick();
    port_addr[1] = 23'h000600;
    port_we[1]   = 1'b0;
    push_txn(1, 23'h000600, 32'h60606060, 1'b0, 1'b1);
    port_req[1] = 1'b1;
    tick();
    check("t6_idle_latency1", 64'(sdram_req), 64'(1));
    serve(1, 0, 1, 32'h60606060, 1'b0, 1'b0);

    repeat (5) tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
